// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared constants and helpers for the async_fifo1 family
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int DSIZE_DEFAULT = 8;
  localparam int ASIZE_DEFAULT = 6;

  // Pointer type for the default geometry; modules re-derive theirs from ASIZE.
  localparam int PTR_W_DEFAULT = ASIZE_DEFAULT + 1;
  typedef logic [PTR_W_DEFAULT-1:0] ptr_default_t;

  function automatic int depth_of(input int asize);
    return 1 << asize;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// fifo_mem : 2**ASIZE x DSIZE register array, synchronous write, async read
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEFAULT,
  parameter int ASIZE = ASIZE_DEFAULT
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = depth_of(ASIZE);

  // Storage is deliberately not reset; pointer reset alone empties the FIFO.
  logic [DSIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/async_fifo1.sv
// ============================================================================
// async_fifo1 : single-clock first-word-fall-through FIFO, wrap-bit pointers
// Revision : 1.0
// ============================================================================
`default_nettype none

module async_fifo1
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEFAULT,
  parameter int ASIZE = ASIZE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty
);

  localparam int PTR_W = ASIZE + 1;
  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;

  logic             push;
  logic             pop;
  logic [DSIZE-1:0] mem_rdata;

  // Same low bits: MSB equal means empty, MSB different means full.
  assign rempty = (wptr_q == rptr_q);
  assign wfull  = (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]) &&
                  (wptr_q[ASIZE] != rptr_q[ASIZE]);

  assign push = winc && !wfull;
  assign pop  = rinc && !rempty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      wptr_d = wptr_q + ptr_t'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk   (clk),
    .wen   (push && !rst),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[ASIZE-1:0]),
    .rdata (mem_rdata)
  );

  assign rdata = rempty ? '0 : mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_async_fifo1.sv
// ============================================================================
// tb_async_fifo1 : directed self-checking bench for async_fifo1
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_async_fifo1;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [7:0] wdata;
  logic       wfull;
  logic       rinc;
  logic [7:0] rdata;
  logic       rempty;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  async_fifo1 #(.DSIZE(8), .ASIZE(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .winc   (winc),
    .wdata  (wdata),
    .wfull  (wfull),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one clock: inputs applied before the edge, outputs settle 1 unit after.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    winc  = w;
    wdata = d;
    rinc  = r;
    @(posedge clk);
    #1;
    winc  = 1'b0;
    rinc  = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_v;

    rst = 1'b1; winc = 1'b1; wdata = 8'h55; rinc = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; winc = 1'b0;
    check("reset_rempty", 32'(rempty), 32'd1);
    check("reset_wfull",  32'(wfull),  32'd0);
    check("reset_rdata",  32'(rdata),  32'h00);

    // Single word
    cycle(1'b1, 8'hA5, 1'b0);
    check("single_rempty", 32'(rempty), 32'd0);
    check("single_rdata",  32'(rdata),  32'hA5);
    cycle(1'b0, 8'h00, 1'b1);
    check("single_pop_rempty", 32'(rempty), 32'd1);
    check("single_pop_rdata",  32'(rdata),  32'h00);

    // Fill, overflow, drain
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      if (i == 62) check("fill_63_wfull", 32'(wfull), 32'd0);
    end
    check("fill_wfull", 32'(wfull), 32'd1);
    check("fill_head",  32'(rdata), 32'h00);
    cycle(1'b1, 8'hFF, 1'b0);
    check("overflow_wfull", 32'(wfull), 32'd1);
    check("overflow_head",  32'(rdata), 32'h00);
    for (int i = 0; i < 64; i++) begin
      check("drain_data", 32'(rdata), 32'(i));
      cycle(1'b0, 8'h00, 1'b1);
      if (i == 0) check("drain_wfull_clear", 32'(wfull), 32'd0);
    end
    check("drain_rempty", 32'(rempty), 32'd1);
    check("drain_rdata",  32'(rdata),  32'h00);

    // Simultaneous push/pop at occupancy 10
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("simul_head", 32'(rdata), 32'h10 + 32'(k));
      cycle(1'b1, 8'h20 + 8'(k), 1'b1);
    end
    for (int i = 0; i < 10; i++) begin
      exp_v = (i < 5) ? 8'h15 + 8'(i) : 8'h20 + 8'(i - 5);
      check("simul_order", 32'(rdata), 32'(exp_v));
      cycle(1'b0, 8'h00, 1'b1);
    end
    check("simul_occ_rempty", 32'(rempty), 32'd1);

    // Simultaneous when full: pop only
    for (int i = 0; i < 64; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0);
    check("full_simul_pre", 32'(wfull), 32'd1);
    cycle(1'b1, 8'hEE, 1'b1);
    check("full_simul_wfull", 32'(wfull), 32'd0);
    check("full_simul_head",  32'(rdata), 32'h81);
    for (int i = 1; i < 64; i++) begin
      check("full_simul_drain", 32'(rdata), 32'h80 + 32'(i));
      cycle(1'b0, 8'h00, 1'b1);
    end
    check("full_simul_no_push", 32'(rempty), 32'd1);

    // Simultaneous when empty: push only
    cycle(1'b1, 8'h77, 1'b1);
    check("empty_simul_rempty", 32'(rempty), 32'd0);
    check("empty_simul_rdata",  32'(rdata),  32'h77);
    cycle(1'b0, 8'h00, 1'b1);
    check("empty_simul_pop", 32'(rempty), 32'd1);

    // Alternating writes/reads with a scoreboard; 400 cycles gives 200 writes,
    // enough to roll the 64-entry address past zero at least three times.
    for (int c = 0; c < 400; c++) begin
      if (c % 2 == 0) begin
        exp_v = 8'($urandom_range(0, 255));
        q.push_back(exp_v);
        cycle(1'b1, exp_v, 1'b0);
      end else if (!rempty) begin
        check("wrap_data", 32'(rdata), 32'(q.pop_front()));
        cycle(1'b0, 8'h00, 1'b1);
      end else begin
        cycle(1'b0, 8'h00, 1'b0);
      end
    end
    while (q.size() > 0) begin
      check("wrap_tail", 32'(rdata), 32'(q.pop_front()));
      cycle(1'b0, 8'h00, 1'b1);
    end
    check("wrap_rempty", 32'(rempty), 32'd1);

    // Mid-run reset with 20 words stored
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0);
    check("midrst_pre", 32'(rempty), 32'd0);
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    check("midrst_rempty", 32'(rempty), 32'd1);
    check("midrst_wfull",  32'(wfull),  32'd0);
    check("midrst_rdata",  32'(rdata),  32'h00);
    cycle(1'b1, 8'h3C, 1'b0);
    check("midrst_next", 32'(rdata), 32'h3C);
    cycle(1'b0, 8'h00, 1'b1);
    check("midrst_final_rempty", 32'(rempty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
